// File: rtl/game_state_ctrl_if.sv
// game_state_ctrl_if: match-sequencer bus; GAME_PAUSE_EN adds pause_btn
interface game_state_ctrl_if;
    logic       start;
    logic       hit_p1;
    logic       hit_p2;
    logic [3:0] round_elapsed;
    logic [1:0] ko_elapsed;
    logic [1:0] end_elapsed;
    logic [1:0] ready_elapsed;
`ifdef GAME_PAUSE_EN
    logic       pause_btn;
`endif
    logic [3:0] GameState;
    logic [1:0] p1_score;
    logic [1:0] p2_score;
    logic [1:0] round_winner;
    logic [3:0] time_remaining;
    modport master (
        input  start, hit_p1, hit_p2, round_elapsed, ko_elapsed, end_elapsed, ready_elapsed,
`ifdef GAME_PAUSE_EN
        input  pause_btn,
`endif
        output GameState, p1_score, p2_score, round_winner, time_remaining
    );
    modport slave (
        output start, hit_p1, hit_p2, round_elapsed, ko_elapsed, end_elapsed, ready_elapsed,
`ifdef GAME_PAUSE_EN
        output pause_btn,
`endif
        input  GameState, p1_score, p2_score, round_winner, time_remaining
    );
endinterface

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: title/ready/play/KO/match-over sequencer; GAME_PAUSE_EN adds PAUSED
module game_state_ctrl #(
    parameter int unsigned ROUND_SECS     = 15,
    parameter int unsigned KO_SECS        = 2,
    parameter int unsigned END_SECS       = 3,
    parameter int unsigned READY_HALFSECS = 3,
    parameter int unsigned WINS_TO_MATCH  = 3
) (
    input logic              Clk,
    input logic              Reset,
    game_state_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        TITLE       = 4'b0000,
        PLAYING     = 4'b0011,
        PAUSED      = 4'b0100,
        ROUND_RESET = 4'b0101,
        KO_PAUSE    = 4'b0110,
        MATCH_OVER  = 4'b1000,
        READY       = 4'b1001
    } state_t;
    localparam logic [3:0] ROUND = 4'(ROUND_SECS);
    localparam logic [1:0] WINS  = 2'(WINS_TO_MATCH);
    state_t     state_q, state_d;
    logic [1:0] p1_score_q, p1_score_d, p2_score_q, p2_score_d;
    logic [1:0] round_winner_q, round_winner_d;
    logic [3:0] time_remaining_q, time_remaining_d;
    logic       start_q;
    logic       start_edge, timeout;
    assign start_edge = bus.start & ~start_q;
    assign timeout    = bus.round_elapsed >= ROUND;
`ifdef GAME_PAUSE_EN
    logic pause_q, pause_edge;
    assign pause_edge = bus.pause_btn & ~pause_q;
`endif
    always_comb begin
        state_d          = state_q;
        p1_score_d       = p1_score_q;
        p2_score_d       = p2_score_q;
        round_winner_d   = round_winner_q;
        time_remaining_d = (state_q inside {TITLE, READY, ROUND_RESET}) ? ROUND :
                           timeout ? 4'd0 : ROUND - bus.round_elapsed;
        case (state_q)
            TITLE: if (start_edge) begin
                state_d    = READY;
                p1_score_d = 2'd0;
                p2_score_d = 2'd0;
            end
            READY: if (bus.ready_elapsed == 2'(READY_HALFSECS)) begin
                state_d        = PLAYING;
                round_winner_d = 2'b00;
            end
            PLAYING:
                // winner code falls out directly as {hit_p2, hit_p1}
                if (bus.hit_p1 || bus.hit_p2) begin
                    state_d        = KO_PAUSE;
                    round_winner_d = {bus.hit_p2, bus.hit_p1};
                    p1_score_d     = (bus.hit_p1 && !bus.hit_p2 && p1_score_q < WINS) ? p1_score_q + 2'd1 : p1_score_q;
                    p2_score_d     = (bus.hit_p2 && !bus.hit_p1 && p2_score_q < WINS) ? p2_score_q + 2'd1 : p2_score_q;
                end
`ifdef GAME_PAUSE_EN
                else if (pause_edge) state_d = PAUSED;
`endif
                else if (timeout) begin
                    state_d        = KO_PAUSE;
                    round_winner_d = 2'b11;
                end
`ifdef GAME_PAUSE_EN
            PAUSED: if (pause_edge) state_d = PLAYING;
`endif
            KO_PAUSE: if (bus.ko_elapsed == 2'(KO_SECS))
                state_d = (p1_score_q == WINS || p2_score_q == WINS) ? MATCH_OVER : ROUND_RESET;
            ROUND_RESET: state_d = READY;
            MATCH_OVER: if (bus.end_elapsed == 2'(END_SECS)) state_d = TITLE;
            default: state_d = TITLE;
        endcase
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q          <= TITLE;
            p1_score_q       <= 2'd0;
            p2_score_q       <= 2'd0;
            round_winner_q   <= 2'b00;
            time_remaining_q <= ROUND;
            start_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            p1_score_q       <= p1_score_d;
            p2_score_q       <= p2_score_d;
            round_winner_q   <= round_winner_d;
            time_remaining_q <= time_remaining_d;
            start_q          <= bus.start;
        end
    end
`ifdef GAME_PAUSE_EN
    always_ff @(posedge Clk) pause_q <= Reset ? 1'b0 : bus.pause_btn;
`endif
    assign bus.GameState      = state_q;
    assign bus.p1_score       = p1_score_q;
    assign bus.p2_score       = p2_score_q;
    assign bus.round_winner   = round_winner_q;
    assign bus.time_remaining = time_remaining_q;
endmodule

// File: tb/tb_game_state_ctrl.sv
// tb_game_state_ctrl: directed test-plan steps plus random play against a rule-level model
module tb_game_state_ctrl;
    localparam int R = 15, KS = 2, ES = 3, RH = 3, W = 3;
    localparam logic [3:0] S_TITLE = 4'b0000, S_PLAY = 4'b0011, S_PAUSE = 4'b0100,
                           S_RR = 4'b0101, S_KO = 4'b0110, S_MO = 4'b1000, S_READY = 4'b1001;
`ifdef GAME_PAUSE_EN
    localparam bit PAUSE_ON = 1'b1;
`else
    localparam bit PAUSE_ON = 1'b0;
`endif
    logic Clk = 1'b0;
    logic Reset;
    int   tests = 0, fails = 0;
    logic [3:0] m_state;
    int   m_p1, m_p2, m_rw, m_tr, m_start, m_pause;
    game_state_ctrl_if bus ();
    game_state_ctrl dut (.Clk(Clk), .Reset(Reset), .bus(bus));
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model by the game rules, then compare every output.
    task automatic step(input int rst = 0, input int st = 0, input int h1 = 0, input int h2 = 0,
                        input int re = 0, input int ko = 0, input int en = 0, input int rd = 0,
                        input int pb = 0);
        logic [3:0] cur;
        int w, s_edge, p_edge;
        Reset = rst != 0;
        bus.start = st != 0; bus.hit_p1 = h1 != 0; bus.hit_p2 = h2 != 0;
        bus.round_elapsed = 4'(re); bus.ko_elapsed = 2'(ko);
        bus.end_elapsed = 2'(en); bus.ready_elapsed = 2'(rd);
`ifdef GAME_PAUSE_EN
        bus.pause_btn = pb != 0;
`endif
        cur = m_state;
        s_edge = (st != 0 && m_start == 0) ? 1 : 0;
        p_edge = (PAUSE_ON && pb != 0 && m_pause == 0) ? 1 : 0;
        m_start = st; m_pause = pb;
        w = h1 + 2 * h2;
        if (rst != 0) begin
            m_state = S_TITLE; m_p1 = 0; m_p2 = 0; m_rw = 0; m_tr = R; m_start = 0; m_pause = 0;
        end else begin
            m_tr = (cur == S_TITLE || cur == S_READY || cur == S_RR) ? R : (re >= R ? 0 : R - re);
            if (cur == S_TITLE) begin
                if (s_edge != 0) begin m_state = S_READY; m_p1 = 0; m_p2 = 0; end
            end else if (cur == S_READY) begin
                if (rd == RH) begin m_state = S_PLAY; m_rw = 0; end
            end else if (cur == S_PLAY) begin
                if (w != 0) begin
                    m_state = S_KO; m_rw = w;
                    if (w == 1 && m_p1 < W) m_p1++;
                    if (w == 2 && m_p2 < W) m_p2++;
                end else if (p_edge != 0) m_state = S_PAUSE;
                else if (re >= R) begin m_state = S_KO; m_rw = 3; end
            end else if (cur == S_PAUSE && PAUSE_ON) begin
                if (p_edge != 0) m_state = S_PLAY;
            end else if (cur == S_KO) begin
                if (ko == KS) m_state = (m_p1 == W || m_p2 == W) ? S_MO : S_RR;
            end else if (cur == S_RR) m_state = S_READY;
            else if (cur == S_MO) begin
                if (en == ES) m_state = S_TITLE;
            end else m_state = S_TITLE;
        end
        @(posedge Clk);
        #1;
        chk("state", bus.GameState, m_state);
        chk("p1_score", {2'b00, bus.p1_score}, 4'(m_p1));
        chk("p2_score", {2'b00, bus.p2_score}, 4'(m_p2));
        chk("round_winner", {2'b00, bus.round_winner}, 4'(m_rw));
        chk("time_remaining", bus.time_remaining, 4'(m_tr));
    endtask

    initial begin
        m_state = S_TITLE; m_p1 = 0; m_p2 = 0; m_rw = 0; m_tr = R; m_start = 0; m_pause = 0;
        step(.rst(1));
        chk("tp_reset_state", bus.GameState, 4'b0000);
        chk("tp_reset_time", bus.time_remaining, 4'd15);
        step(.st(1));
        chk("tp_ready", bus.GameState, 4'b1001);
        step(.rd(3));
        chk("tp_playing", bus.GameState, 4'b0011);
        chk("tp_play_time", bus.time_remaining, 4'd15);
        step(.re(5), .h1(1));
        chk("tp_ko", bus.GameState, 4'b0110);
        chk("tp_p1_win", {2'b00, bus.p1_score}, 4'd1);
        chk("tp_rw_p1", {2'b00, bus.round_winner}, 4'b0001);
        chk("tp_time10", bus.time_remaining, 4'd10);
        step(.ko(2));
        chk("tp_round_reset", bus.GameState, 4'b0101);
        step(.ko(2));
        chk("tp_rr_one_cycle", bus.GameState, 4'b1001);
        step(.rd(3));
        step(.h1(1), .h2(1), .re(15));
        chk("tp_draw_rw", {2'b00, bus.round_winner}, 4'b0011);
        chk("tp_draw_state", bus.GameState, 4'b0110);
        chk("tp_draw_p1", {2'b00, bus.p1_score}, 4'd1);
        for (int i = 0; i < 3; i++) begin
            step(.ko(2));
            step();
            step(.rd(3));
            step(.h2(1));
        end
        chk("tp_p2_three", {2'b00, bus.p2_score}, 4'd3);
        step(.ko(2));
        chk("tp_match_over", bus.GameState, 4'b1000);
        step(.st(1));
        chk("tp_mo_hold", bus.GameState, 4'b1000);
        step(.st(1), .en(3));
        chk("tp_title", bus.GameState, 4'b0000);
        chk("tp_title_p2", {2'b00, bus.p2_score}, 4'd3);
        for (int i = 0; i < 3; i++) step(.st(1));
        chk("tp_held_start", bus.GameState, 4'b0000);
        step();
        step(.st(1));
        chk("tp_restart", bus.GameState, 4'b1001);
        chk("tp_restart_p2", {2'b00, bus.p2_score}, 4'd0);
`ifdef GAME_PAUSE_EN
        step(.rd(3));
        step(.pb(1));
        chk("tp_paused", bus.GameState, 4'b0100);
        step(.pb(1), .h1(1), .re(15));
        chk("tp_pause_hit", {2'b00, bus.p1_score}, 4'd0);
        step();
        step(.pb(1));
        chk("tp_resume", bus.GameState, 4'b0011);
        step();
        step(.pb(1));
        step(.rst(1));
        chk("tp_pause_reset", bus.GameState, 4'b0000);
`endif
        for (int i = 0; i < 4000; i++)
            step(.rst(int'($urandom_range(0, 299) == 0)),
                 .st(int'($urandom_range(0, 3) == 0)),
                 .h1(int'($urandom_range(0, 9) == 0)),
                 .h2(int'($urandom_range(0, 9) == 0)),
                 .re(int'($urandom_range(0, 15))),
                 .ko(int'($urandom_range(0, 3))),
                 .en(int'($urandom_range(0, 3))),
                 .rd(int'($urandom_range(0, 3))),
                 .pb(int'($urandom_range(0, 7) == 0)));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
